tt_lut_gate: RTL and testbench
==============================

# tt_lut_gate

Sequential, parametrised successor to the fixed 4-input truth-table gates: an N-input lookup-table gate whose truth table loads at runtime over a serial configuration port, with valid/ready evaluation traffic and a small output FIFO. It sits where a hard-wired truth-table gate sits in the design flow. It lets one block emulate any N-input function, 0x850E by default, in simulation and on the bench without resynthesis.

## Interface
- `N_IN`, 4, number of gate inputs (1..6)
- `TT_W`, 2**N_IN, truth-table width (derived, do not override)
- `RESET_TT`, 16'h850E, active truth table after reset (zero-extended or truncated to TT_W)
- `DEPTH`, 2, output FIFO depth (power of two, ≥2)
- `clk` in 1 single clock, rising edge
- `rst_n` in 1 asynchronous, active-low reset
- `in_valid` in 1 evaluation request valid
- `in_ready` out 1 request accepted when in_valid & in_ready
- `in_vec` in N_IN input combination; index = in_vec as unsigned
- `out_valid` out 1 result available
- `out_ready` in 1 consumer accepts result
- `out_bit` out 1 evaluated gate output
- `cfg_start` in 1 begins a truth-table load
- `cfg_valid` in 1 qualifies cfg_bit
- `cfg_bit` in 1 serial truth-table bit, LSB (index 0) first
- `cfg_busy` out 1 load or commit in progress
- `eval_count` out 16 results delivered since reset, wraps

## Operation
- Evaluation: on accept, out_bit = active_tt[in_vec], pushed to the FIFO. The table value is captured at accept time, so in-flight results never change on reload.
- in_ready = (state == IDLE) & !fifo_full. A simultaneous pop frees space in the same cycle, so in_ready also asserts when the FIFO is full and out_ready & out_valid.
- FSM states:
  - IDLE: cfg_start → LOAD, with bit counter cleared and shadow cleared.
  - LOAD: each cfg_valid shifts cfg_bit into shadow[bitcnt] and increments bitcnt. When bitcnt reaches TT_W−1 with cfg_valid, go to COMMIT.
  - COMMIT: active_tt ← shadow for one cycle, then IDLE.
- cfg_start during LOAD restarts the load: counter is cleared and partial shadow is discarded. cfg_start during COMMIT is ignored.
- cfg_valid outside LOAD is ignored. cfg_start and in_valid in the same IDLE cycle: the request is accepted with the old table, then LOAD begins.
- Output side keeps draining during LOAD and COMMIT.
- eval_count increments on each out_valid & out_ready and wraps 16'hFFFF → 0.
- bitcnt is $clog2(TT_W) bits wide, with no overflow past TT_W−1.
- Reset (async, any state): state = IDLE, active_tt = RESET_TT, shadow = 0, FIFO empty, eval_count = 0. A mid-load reset discards the partial table.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_bit = 0, cfg_busy = 0, eval_count = 0.
- Latency: accept at edge k gives out_valid high after edge k, i.e. usable in cycle k+1. Throughput is 1 result per cycle when out_ready is held high.
- out_bit and out_valid are driven from FIFO registers, with no combinational path from in_* to out_*.
- cfg_busy is high from the cycle after cfg_start is sampled through the COMMIT cycle.
- The new table applies to requests accepted from the first IDLE cycle after COMMIT.
- A full load takes TT_W cfg_valid cycles plus 1 COMMIT cycle (minimum 17 cycles plus start for N_IN = 4).
- out_valid & !out_ready holds out_bit stable (standard valid/ready rule). in_ready may drop without in_valid.

## Structure
- Package `tt_lut_pkg`:
  - FSM enum `tt_state_e` {IDLE, LOAD, COMMIT}
  - `EVAL_CNT_W = 16`
  - `DEFAULT_TT = 16'h850E`
- Sub-module `tt_out_fifo`: 1-bit synchronous FIFO of DEPTH entries. Ports are push, pop, full, empty, and dout. It supports simultaneous push/pop when full or empty.
- Top level holds the FSM, shadow and active registers, index mux, and counter.

## Test plan
- Reset default, table 0x850E: inputs 0x0, 0x1, 0x4, 0xF → outputs 0, 1, 0, 1 at 1-cycle latency. eval_count reads 4.
- Load 16'h8000 (AND4) serially. During load in_ready = 0 and cfg_busy = 1. After COMMIT: 0xF → 1, 0xE → 0.
- Backpressure: hold out_ready = 0 and send 3 requests. in_ready drops after 2 accepted (DEPTH = 2). Release, then results arrive in order with no loss or duplication.
- Restart: cfg_start, 5 bits, cfg_start again, then 16 bits of 0xFFFF. Active table is 0xFFFF and the partial load has no effect.
- Reset mid-load (assert rst_n = 0 after 8 bits): active table is 0x850E again and the FIFO is empty. 0x1 → 1 afterwards.
- Counter wrap: force 65536 deliveries with streaming valid/ready held high. eval_count returns to 0 and throughput stays 1/cycle.

Source files
------------

// File: rtl/tt_lut_pkg.sv
// tt_lut_pkg: shared types and constants for the runtime-loadable LUT gate.
// Holds the config FSM state enum, counter width and default truth table.
package tt_lut_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } tt_state_e;

  localparam int EVAL_CNT_W = 16;

  localparam logic [15:0] DEFAULT_TT = 16'h850E;

endpackage

// File: rtl/tt_out_fifo.sv
// tt_out_fifo: 1-bit synchronous FIFO, DEPTH entries (power of two, >=2).
// Ports: push/din write, pop read, full/empty flags, dout = head entry.
module tt_out_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] r_mem;
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_cnt;

  logic w_pop;
  logic w_push;

  assign empty = (r_cnt == '0);
  assign full  = (r_cnt == (AW+1)'(DEPTH));

  // A pop in the same cycle frees a slot, so a full FIFO still takes a push.
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);

  // Gated so an empty FIFO always presents 0.
  assign dout = r_mem[r_rd] & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= din;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/tt_lut_gate.sv
// tt_lut_gate: N-input LUT gate with serial truth-table load and FIFO output.
// Ports: in_* request (valid/ready), out_* result, cfg_* serial load, eval_count.
module tt_lut_gate
  import tt_lut_pkg::*;
#(
  parameter int          N_IN     = 4,
  parameter int          TT_W     = 2**N_IN,
  parameter logic [63:0] RESET_TT = 64'(DEFAULT_TT),
  parameter int          DEPTH    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_IN-1:0]       in_vec,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_bit,
  input  logic                  cfg_start,
  input  logic                  cfg_valid,
  input  logic                  cfg_bit,
  output logic                  cfg_busy,
  output logic [EVAL_CNT_W-1:0] eval_count
);

  localparam int CNT_W = (TT_W > 1) ? $clog2(TT_W) : 1;

  localparam logic [TT_W-1:0] RST_TT = RESET_TT[TT_W-1:0];

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(TT_W - 1);

  tt_state_e        r_state;
  logic [TT_W-1:0]  r_shadow;
  logic [TT_W-1:0]  r_active;
  logic [CNT_W-1:0] r_bitcnt;
  logic [EVAL_CNT_W-1:0] r_eval_cnt;

  logic w_full;
  logic w_empty;
  logic w_accept;
  logic w_deliver;
  logic w_lut_bit;

  assign out_valid = ~w_empty;
  assign w_deliver = out_valid & out_ready;

  assign in_ready = (r_state == IDLE) & (~w_full | w_deliver);
  assign w_accept = in_valid & in_ready;

  // Table bit is captured at accept, so a later reload never alters it.
  assign w_lut_bit = r_active[in_vec];

  assign cfg_busy   = (r_state != IDLE);
  assign eval_count = r_eval_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_shadow <= '0;
      r_active <= RST_TT;
      r_bitcnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cfg_start) begin
            r_state  <= LOAD;
            r_bitcnt <= '0;
            r_shadow <= '0;
          end
        end
        LOAD: begin
          if (cfg_start) begin
            r_bitcnt <= '0;
            r_shadow <= '0;
          end else if (cfg_valid) begin
            r_shadow[r_bitcnt] <= cfg_bit;
            if (r_bitcnt == LAST_BIT) begin
              r_state <= COMMIT;
            end else begin
              r_bitcnt <= r_bitcnt + CNT_W'(1);
            end
          end
        end
        COMMIT: begin
          r_active <= r_shadow;
          r_state  <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_eval_cnt <= '0;
    end else if (w_deliver) begin
      r_eval_cnt <= r_eval_cnt + EVAL_CNT_W'(1);
    end
  end

  tt_out_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_accept),
    .din   (w_lut_bit),
    .pop   (w_deliver),
    .full  (w_full),
    .empty (w_empty),
    .dout  (out_bit)
  );

endmodule

// File: tb/tb_tt_lut_gate.sv
// tb_tt_lut_gate: directed self-checking bench for tt_lut_gate.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_tt_lut_gate;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_vec;
  logic        out_valid;
  logic        out_ready;
  logic        out_bit;
  logic        cfg_start;
  logic        cfg_valid;
  logic        cfg_bit;
  logic        cfg_busy;
  logic [15:0] eval_count;

  int total = 0;
  int bad   = 0;

  tt_lut_gate #(
    .N_IN  (4),
    .DEPTH (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_vec     (in_vec),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_bit    (out_bit),
    .cfg_start  (cfg_start),
    .cfg_valid  (cfg_valid),
    .cfg_bit    (cfg_bit),
    .cfg_busy   (cfg_busy),
    .eval_count (eval_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request with out_ready high: result visible 1 cycle later, then popped.
  task automatic eval1(input string tag,
                       input logic [3:0] v,
                       input logic exp);
    in_valid  = 1'b1;
    in_vec    = v;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_bit"}, 32'(out_bit), 32'(exp));
    tick();
  endtask

  task automatic shift_bits(input logic [15:0] val, input int n);
    for (int i = 0; i < n; i++) begin
      cfg_valid = 1'b1;
      cfg_bit   = val[i];
      tick();
    end
    cfg_valid = 1'b0;
    cfg_bit   = 1'b0;
  endtask

  initial begin
    int stalls;
    int gaps;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b0;
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    cfg_bit   = 1'b0;
    #23;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_bit", 32'(out_bit), 32'd0);
    chk("rst_cfg_busy", 32'(cfg_busy), 32'd0);
    chk("rst_eval_count", 32'(eval_count), 32'd0);
    rst_n = 1'b1;
    tick();

    // Default table 0x850E, streamed back to back.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_vec    = 4'h0;
    tick();
    chk("def0", 32'(out_bit), 32'd0);
    chk("def0_valid", 32'(out_valid), 32'd1);
    in_vec = 4'h1;
    tick();
    chk("def1", 32'(out_bit), 32'd1);
    in_vec = 4'h4;
    tick();
    chk("def4", 32'(out_bit), 32'd0);
    in_vec = 4'hF;
    tick();
    chk("defF", 32'(out_bit), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("def_count", 32'(eval_count), 32'd4);
    chk("def_drained", 32'(out_valid), 32'd0);

    // Load AND4 = 0x8000.
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("ld_busy", 32'(cfg_busy), 32'd1);
    chk("ld_in_ready", 32'(in_ready), 32'd0);
    shift_bits(16'h8000, 16);
    chk("ld_commit_busy", 32'(cfg_busy), 32'd1);
    chk("ld_commit_ready", 32'(in_ready), 32'd0);
    tick();
    chk("ld_done_busy", 32'(cfg_busy), 32'd0);
    chk("ld_done_ready", 32'(in_ready), 32'd1);
    eval1("and_F", 4'hF, 1'b1);
    eval1("and_E", 4'hE, 1'b0);

    // Backpressure with DEPTH = 2.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_vec    = 4'hF;
    chk("bp_ready0", 32'(in_ready), 32'd1);
    tick();
    in_vec = 4'hE;
    chk("bp_ready1", 32'(in_ready), 32'd1);
    tick();
    in_vec = 4'hF;
    chk("bp_full", 32'(in_ready), 32'd0);
    tick();
    chk("bp_still_full", 32'(in_ready), 32'd0);
    chk("bp_hold", 32'(out_bit), 32'd1);
    out_ready = 1'b1;
    #1;
    chk("bp_popfree", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_r2", 32'(out_bit), 32'd0);
    tick();
    chk("bp_r3_valid", 32'(out_valid), 32'd1);
    chk("bp_r3", 32'(out_bit), 32'd1);
    tick();
    chk("bp_empty", 32'(out_valid), 32'd0);
    chk("bp_count", 32'(eval_count), 32'd9);

    // Restart: 5 zero bits, restart, then 16 ones.
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    shift_bits(16'h0000, 5);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    shift_bits(16'hFFFF, 16);
    chk("rs_busy", 32'(cfg_busy), 32'd1);
    tick();
    chk("rs_idle", 32'(cfg_busy), 32'd0);
    eval1("rs_0", 4'h0, 1'b1);
    eval1("rs_7", 4'h7, 1'b1);
    eval1("rs_E", 4'hE, 1'b1);

    // Reset during load with a result parked in the FIFO.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_vec    = 4'h0;
    tick();
    in_valid = 1'b0;
    chk("mr_parked", 32'(out_valid), 32'd1);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    shift_bits(16'h00FF, 8);
    rst_n = 1'b0;
    #2;
    chk("mr_fifo_empty", 32'(out_valid), 32'd0);
    chk("mr_busy", 32'(cfg_busy), 32'd0);
    chk("mr_count", 32'(eval_count), 32'd0);
    rst_n = 1'b1;
    tick();
    eval1("mr_1", 4'h1, 1'b1);
    eval1("mr_0", 4'h0, 1'b0);
    chk("mr_count2", 32'(eval_count), 32'd2);

    // Stream until eval_count wraps (2 + 65534 = 65536).
    stalls    = 0;
    gaps      = 0;
    in_valid  = 1'b1;
    in_vec    = 4'h1;
    out_ready = 1'b1;
    for (int i = 0; i < 65534; i++) begin
      if (!in_ready) stalls++;
      if (i > 0 && !out_valid) gaps++;
      tick();
    end
    in_valid = 1'b0;
    chk("wr_stalls", 32'(stalls), 32'd0);
    chk("wr_gaps", 32'(gaps), 32'd0);
    chk("wr_pre", 32'(eval_count), 32'h0000FFFF);
    chk("wr_last_valid", 32'(out_valid), 32'd1);
    tick();
    chk("wr_wrap", 32'(eval_count), 32'd0);
    chk("wr_empty", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
